// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//   Round-robin arbiter for the shared 16-bit SLC-3 datapath bus. Up to four
//   gate requesters (0=PC, 1=MDR, 2=ALU, 3=MARMUX) compete for the bus. One
//   owner is granted at a time. A hold limit forces a handoff once an owner
//   has held the bus HOLD_MAX cycles while someone else is waiting.
//
//   Optional feature macro: BUS_ARB_TURNAROUND_EN
//     When defined, every handoff between two different owners inserts one
//     dead TURN cycle, and the winner is re-chosen at TURN exit.
//     When undefined, handoffs are back-to-back.
//
// Ports
//   Clk        in   system clock, rising-edge active
//   Reset      in   asynchronous active-low reset
//   req[3:0]   in   level-sensitive bus requests
//   gnt[3:0]   out  one-hot grant, or zero when there is no owner (registered)
//   sel[1:0]   out  bus mux select = owner index, changes only on a grant
//   bus_en     out  |gnt (registered)
//   owner_cnt  out  cycles held by the current owner minus 1, saturating
//
// State table
//   IDLE | no owner, gnt=0, sel holds the last owner
//   OWN  | ptr_q is the owner and gnt_q is one-hot
//   TURN | (macro only) one dead cycle between two different owners
// ---------------------------------------------------------------------------
module bus_arbiter #(
    parameter  int HOLD_MAX = 8,
    localparam int CW       = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [3:0]    req,
    output logic [3:0]    gnt,
    output logic [1:0]    sel,
    output logic          bus_en,
    output logic [CW-1:0] owner_cnt
);

    localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX - 1);

`ifdef BUS_ARB_TURNAROUND_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1
    } state_t;
`endif

    state_t        state_q, state_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [1:0]    sel_q, sel_d;
    logic          bus_en_q, bus_en_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    ptr_q, ptr_d;

    // Returns {found, index}. The scan runs base+1 .. base+4 (mod 4), so the
    // index at base has the lowest priority.
    function automatic logic [2:0] find_winner(input logic [3:0] r,
                                               input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            cand = base + 2'(k);
            if (!res[2] && r[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    logic [3:0] others;
    logic       own_req;
    logic [2:0] win_all;
    logic [2:0] win_oth;

    // While in OWN, ptr_q is the owner index.
    assign others  = req & ~(4'b0001 << ptr_q);
    assign own_req = req[ptr_q];
    assign win_all = find_winner(req, ptr_q);
    assign win_oth = find_winner(others, ptr_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;

        case (state_q)
            IDLE: begin
                gnt_d = 4'b0000;
                cnt_d = '0;
                if (win_all[2]) begin
                    state_d = OWN;
                    gnt_d   = 4'b0001 << win_all[1:0];
                    sel_d   = win_all[1:0];
                    ptr_d   = win_all[1:0];
                end
            end

            OWN: begin
                if (own_req && ((others == 4'b0000) || (cnt_q != CNT_MAX))) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (others != 4'b0000) begin
                    // Expired hold with a waiter, or owner released with a
                    // waiter. The owner is never its own successor here.
`ifdef BUS_ARB_TURNAROUND_EN
                    state_d = TURN;
                    gnt_d   = 4'b0000;
                    cnt_d   = '0;
`else
                    gnt_d   = 4'b0001 << win_oth[1:0];
                    sel_d   = win_oth[1:0];
                    ptr_d   = win_oth[1:0];
                    cnt_d   = '0;
`endif
                end else begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    cnt_d   = '0;
                end
            end

`ifdef BUS_ARB_TURNAROUND_EN
            TURN: begin
                // ptr_q still names the previous owner, so it stays at the
                // bottom of the priority order unless it is alone.
                cnt_d = '0;
                gnt_d = 4'b0000;
                if (win_all[2]) begin
                    state_d = OWN;
                    gnt_d   = 4'b0001 << win_all[1:0];
                    sel_d   = win_all[1:0];
                    ptr_d   = win_all[1:0];
                end else begin
                    state_d = IDLE;
                end
            end
`endif

            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                cnt_d   = '0;
            end
        endcase

        bus_en_d = |gnt_d;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            gnt_q    <= 4'b0000;
            sel_q    <= 2'b00;
            bus_en_q <= 1'b0;
            cnt_q    <= '0;
            ptr_q    <= 2'd3;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            sel_q    <= sel_d;
            bus_en_q <= bus_en_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign bus_en    = bus_en_q;
    assign owner_cnt = cnt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

    localparam int HM = 8;
    localparam int CW = $clog2(HM);

    logic          Clk = 1'b0;
    logic          Reset;
    logic [3:0]    req;
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic          bus_en;
    logic [CW-1:0] owner_cnt;

    bus_arbiter #(.HOLD_MAX(HM)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .bus_en    (bus_en),
        .owner_cnt (owner_cnt)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string         tag;
        logic [3:0]    gnt;
        logic [1:0]    sel;
        logic          en;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic push(input string tag, input logic [3:0] g, input logic [1:0] s,
                        input logic e, input int c);
        exp_t x;
        x.tag = tag;
        x.gnt = g;
        x.sel = s;
        x.en  = e;
        x.cnt = CW'(c);
        sb.push_back(x);
    endtask

    task automatic check_out();
        exp_t x;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $error("FAIL sb_empty: DUT output with no expectation queued");
        end else begin
            x = sb.pop_front();
            assert ({gnt, sel, bus_en, owner_cnt} === {x.gnt, x.sel, x.en, x.cnt})
            else begin
                n_bad++;
                $error("FAIL %s: got gnt=%b sel=%b bus_en=%b owner_cnt=%0d, want gnt=%b sel=%b bus_en=%b owner_cnt=%0d",
                       x.tag, gnt, sel, bus_en, owner_cnt, x.gnt, x.sel, x.en, x.cnt);
            end
        end
    endtask

    // Drive req for one edge, queue the expected registered result, check it.
    task automatic step(input logic [3:0] r, input string tag, input logic [3:0] g,
                        input logic [1:0] s, input logic e, input int c);
        @(negedge Clk);
        req = r;
        push(tag, g, s, e, c);
        @(posedge Clk);
        #1;
        check_out();
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b0;
        req   = 4'b0000;
        #2;
        push("reset", 4'b0000, 2'b00, 1'b0, 0);
        check_out();
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    initial begin
        Reset = 1'b1;
        req   = 4'b0000;
        #1;
        Reset = 1'b0;
        #3;
        push("por", 4'b0000, 2'b00, 1'b0, 0);
        check_out();
        Reset = 1'b1;

        // Lone requester 0: granted every cycle, owner_cnt saturates at HM-1.
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            step(4'b0001, "solo0", 4'b0001, 2'b00, 1'b1, (k - 1 < HM - 1) ? k - 1 : HM - 1);
        end
        step(4'b0000, "solo0_rel", 4'b0000, 2'b00, 1'b0, 0);

`ifdef BUS_ARB_TURNAROUND_EN
        // 0 and 1 contend: 8 cycles of 0, one dead cycle, 8 cycles of 1,
        // dead cycle, back to 0.
        do_reset();
        for (int k = 0; k < HM; k++) begin
            step(4'b0011, "turn_own0", 4'b0001, 2'b00, 1'b1, k);
        end
        step(4'b0011, "turn_gap0", 4'b0000, 2'b00, 1'b0, 0);
        for (int k = 0; k < HM; k++) begin
            step(4'b0011, "turn_own1", 4'b0010, 2'b01, 1'b1, k);
        end
        step(4'b0011, "turn_gap1", 4'b0000, 2'b01, 1'b0, 0);
        step(4'b0011, "turn_back0", 4'b0001, 2'b00, 1'b1, 0);
        step(4'b0000, "turn_rel", 4'b0000, 2'b00, 1'b0, 0);
`else
        // 0 and 2 contend: alternate in blocks of HM with no dead cycle.
        do_reset();
        for (int k = 0; k < 4 * HM; k++) begin
            if (((k / HM) % 2) == 0) begin
                step(4'b0101, "pre_own0", 4'b0001, 2'b00, 1'b1, k % HM);
            end else begin
                step(4'b0101, "pre_own2", 4'b0100, 2'b10, 1'b1, k % HM);
            end
        end

        // All four request; each owner drops after 2 cycles and re-raises a
        // cycle later. Order 0,1,2,3,0 with two cycles each.
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            logic [3:0] r;
            logic [3:0] all1;
            int         own;
            all1 = 4'b1111;
            r    = all1;
            if ((k % 2 == 1) && (k >= 3)) begin
                r[((k - 3) / 2) % 4] = 1'b0;
            end
            own = ((k - 1) / 2) % 4;
            step(r, "rr_all", 4'b0001 << own, 2'(own), 1'b1, (k - 1) % 2);
        end
        step(4'b0000, "rr_rel", 4'b0000, 2'b00, 1'b0, 0);
`endif

        // Async reset while owner 2 holds the bus.
        do_reset();
        step(4'b0100, "own2_a", 4'b0100, 2'b10, 1'b1, 0);
        step(4'b0100, "own2_b", 4'b0100, 2'b10, 1'b1, 1);
        #2;
        Reset = 1'b0;
        #1;
        push("async_rst", 4'b0000, 2'b00, 1'b0, 0);
        check_out();
        @(negedge Clk);
        Reset = 1'b1;
        req   = 4'b1001;
        push("post_rst", 4'b0001, 2'b00, 1'b1, 0);
        @(posedge Clk);
        #1;
        check_out();

        // Owner 1 releases to IDLE; sel holds; regrant restarts owner_cnt.
        do_reset();
        step(4'b0010, "own1_0", 4'b0010, 2'b01, 1'b1, 0);
        step(4'b0010, "own1_1", 4'b0010, 2'b01, 1'b1, 1);
        step(4'b0010, "own1_2", 4'b0010, 2'b01, 1'b1, 2);
        step(4'b0000, "own1_rel", 4'b0000, 2'b01, 1'b0, 0);
        step(4'b0000, "idle_hold", 4'b0000, 2'b01, 1'b0, 0);
        // A mid-cycle req change must not reach the registered outputs.
        @(negedge Clk);
        req = 4'b1111;
        #1;
        push("no_comb", 4'b0000, 2'b01, 1'b0, 0);
        check_out();
        req = 4'b0000;
        step(4'b0010, "regrant1", 4'b0010, 2'b01, 1'b1, 0);
        step(4'b0000, "final_rel", 4'b0000, 2'b01, 1'b0, 0);

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL sb_leftover: %0d expectations left, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter and sequencer for the shared 16-bit datapath bus of the Lab 6 SLC-3. It accepts up to four gate requests (PC, MDR, ALU, MARMUX), grants the bus to exactly one requester at a time, and drives the 2-bit select of the 16-bit 4:1 bus mux. A hold limit provides fairness, so no requester is starved while another holds its request.

## Interface

- HOLD_MAX, 8: maximum consecutive grant cycles for one owner while any other requester is waiting. Legal range is 2..256.
- Clk  in  1  system clock; all state updates on its rising edge
- Reset  in  1  asynchronous, active-low reset
- req  in  4  bus requests; req[i] high means requester i wants the bus this cycle
- gnt  out  4  one-hot grant, or 4'b0000 when no owner; registered
- sel  out  2  bus mux select, equal to the owner's index; registered
- bus_en  out  1  high when gnt is nonzero; registered, equals |gnt
- owner_cnt  out  $clog2(HOLD_MAX)  cycles the current owner has held the bus, minus 1; registered

## Operation

- Reset (Reset=0) applies asynchronously:
  - gnt=4'b0000, sel=2'b00, bus_en=0, owner_cnt=0.
  - Round-robin pointer ptr=3, so requester 0 has first priority after reset.
  - State=IDLE.
- States: IDLE, OWN, and TURN (TURN exists only with the macro; see Configuration).
- Winner search: the first i with req[i]=1, scanning indices ptr+1, ptr+2, ptr+3, ptr+4, all mod 4. On every grant, ptr is set to the winner.
- IDLE:
  - gnt=0, bus_en=0, sel holds its last value.
  - Any req high moves to OWN with the winner granted and owner_cnt=0.
- OWN, owner o:
  - req[o]=1 and no other req: stay. owner_cnt increments and saturates at HOLD_MAX-1.
  - req[o]=1, owner_cnt=HOLD_MAX-1, and another req high: preempt. Hand off to the winner, searched from o+1, so o is excluded.
  - req[o]=1 and owner_cnt<HOLD_MAX-1: stay, increment owner_cnt.
  - req[o]=0 and another req high: hand off to the winner.
  - req[o]=0 and no req high: go to IDLE.
- Handoff without the macro: the new gnt, sel and owner_cnt=0 appear in the next cycle, back-to-back with no dead cycle.
- Requests are level-sensitive. A requester that drops req before it is granted simply loses that arbitration; nothing is queued.
- gnt is always one-hot or zero. sel changes only on a grant.

## Timing

- Request-to-grant latency from IDLE: 1 cycle. req sampled at edge N gives gnt valid after edge N.
- Release latency: owner drops req at edge N; gnt changes after edge N.
- Preemption: a held owner with a waiting competitor holds exactly HOLD_MAX cycles.
- Worst-case wait for a continuously requesting requester: 3*HOLD_MAX cycles, plus 3 cycles with the macro.
- Reset asserted mid-grant: outputs clear immediately, without waiting for Clk. The first grant after release follows the IDLE rules with ptr=3.
- All outputs come from flops. There is no combinational path from req to any output.

## Configuration

- BUS_ARB_TURNAROUND_EN defined:
  - Every handoff between two different owners passes through TURN for exactly one cycle.
  - In TURN: gnt=0, bus_en=0, sel holds the previous owner, owner_cnt=0.
  - The winner is re-evaluated from req at TURN exit. If no req is high, go to IDLE.
  - Release to IDLE does not use TURN.
- BUS_ARB_TURNAROUND_EN not defined: TURN is not implemented and handoffs are back-to-back.

## Test plan

- Reset, then req=4'b0001 held for 20 cycles, HOLD_MAX=8 -> gnt=4'b0001 and sel=00 from cycle 1 through cycle 20. owner_cnt saturates at 7. No preemption.
- req=4'b0101 held continuously -> gnt=0001 for 8 cycles, then 0100 for 8, then 0001 for 8, repeating. sel alternates 00/10. No cycle has gnt=0 (macro off).
- req=4'b1111 held, each owner drops its req after 2 granted cycles then re-raises it one cycle later -> grant order 0,1,2,3,0 with 2 cycles each.
- Macro on, req=4'b0011 held -> gnt=0001 for 8 cycles, then 1 cycle of gnt=0000 with sel=00, then 0010 for 8 cycles.
- Owner 2 holding (gnt=0100) and Reset pulsed low mid-cycle -> gnt=0, sel=00, bus_en=0 before the next edge. After release with req=4'b1001 -> gnt=0001 one cycle later.
- Owner 1 drops req, no other requests -> gnt=0000 and bus_en=0 next cycle, sel stays 01. A new req=4'b0010 is then granted with owner_cnt=0.
